// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port RAM between the CPU data port and a DMA/loader
//   port. New accesses are issued only from IDLE, at most one per cycle.
//   Ties go to the requester that was not granted last. Reads hold the
//   FSM for one extra cycle while RAM data returns.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | arbitrate and issue at most one access this cycle
//   CPU_RD | CPU read data on mem_rdata, routed combinationally
//   DMA_RD | DMA read data on mem_rdata, registered into dma_rdata
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   cpu_rd/wr/addr/wdata/rw_type CPU request (held while stalled)
//   cpu_stall, cpu_rdata        CPU freeze and read data
//   dma_req/we/addr/wdata/rw_type DMA request (held until dma_gnt)
//   dma_gnt, dma_rvalid, dma_rdata DMA grant pulse and read return
//   mem_en/we/addr/wdata/rw_type RAM port, mem_rdata one cycle after read
module mem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [2:0]    cpu_rw_type,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  input  logic [2:0]    dma_rw_type,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [2:0]    mem_rw_type,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    DMA_RD = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DMA = 1'b1
  } gnt_t;

  state_t        state_q, state_d;
  gnt_t          last_gnt_q, last_gnt_d;
  logic          dma_rvalid_q, dma_rvalid_d;
  logic [DW-1:0] dma_rdata_q, dma_rdata_d;

  logic cpu_req;
  logic gnt_cpu;
  logic gnt_dma;

  // A simultaneous rd+wr is treated as a write.
  assign cpu_req = cpu_rd | cpu_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_gnt_q   <= GNT_DMA;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_gnt_d   = last_gnt_q;
    dma_rvalid_d = 1'b0;
    dma_rdata_d  = dma_rdata_q;
    gnt_cpu      = 1'b0;
    gnt_dma      = 1'b0;
    cpu_stall    = 1'b0;
    cpu_rdata    = '0;

    // While rst is high nothing is granted and the CPU is not stalled;
    // the register file takes its reset values at the edge regardless.
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (cpu_req && (!dma_req || last_gnt_q == GNT_DMA)) begin
            gnt_cpu = 1'b1;
          end else if (dma_req) begin
            gnt_dma = 1'b1;
          end

          if (gnt_cpu) begin
            last_gnt_d = GNT_CPU;
            // Writes finish in the grant cycle; reads stall for the return.
            if (!cpu_wr) begin
              cpu_stall = 1'b1;
              state_d   = CPU_RD;
            end
          end else begin
            cpu_stall = cpu_req;
          end

          if (gnt_dma) begin
            last_gnt_d = GNT_DMA;
            if (!dma_we) begin
              state_d = DMA_RD;
            end
          end
        end
        CPU_RD: begin
          state_d = IDLE;
        end
        DMA_RD: begin
          cpu_stall    = cpu_req;
          dma_rvalid_d = 1'b1;
          dma_rdata_d  = mem_rdata;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Read data is routed while in CPU_RD only.
    if (state_q == CPU_RD) begin
      cpu_rdata = mem_rdata;
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_rw_type = '0;
    if (gnt_cpu) begin
      mem_en      = 1'b1;
      mem_we      = cpu_wr;
      mem_addr    = cpu_addr;
      mem_wdata   = cpu_wdata;
      mem_rw_type = cpu_rw_type;
    end else if (gnt_dma) begin
      mem_en      = 1'b1;
      mem_we      = dma_we;
      mem_addr    = dma_addr;
      mem_wdata   = dma_wdata;
      mem_rw_type = dma_rw_type;
    end
  end

  assign dma_gnt    = gnt_dma;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a small behavioural RAM that
//   returns read data one cycle after a read is issued.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd, cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [2:0]    cpu_rw_type;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          dma_req, dma_we;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [2:0]    dma_rw_type;
  logic          dma_gnt, dma_rvalid;
  logic [DW-1:0] dma_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_rw_type;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_rd      (cpu_rd),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rw_type (cpu_rw_type),
    .cpu_stall   (cpu_stall),
    .cpu_rdata   (cpu_rdata),
    .dma_req     (dma_req),
    .dma_we      (dma_we),
    .dma_addr    (dma_addr),
    .dma_wdata   (dma_wdata),
    .dma_rw_type (dma_rw_type),
    .dma_gnt     (dma_gnt),
    .dma_rvalid  (dma_rvalid),
    .dma_rdata   (dma_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rw_type (mem_rw_type),
    .mem_rdata   (mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_rw_type = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_rw_type = '0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h20] = 32'h1234_5678;
    ram[8'h40] = 32'hCAFE_F00D;
    mem_rdata = '0;
    rst = 1;
    clear_inputs();

    // Reset gates all issue even with both requesting.
    @(negedge clk); cpu_rd = 1; dma_req = 1; #1;
    check("rst_mem_en", mem_en, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_dma_gnt", dma_gnt, 0);
    check("rst_rvalid", dma_rvalid, 0);
    check("rst_mem_addr", mem_addr, 0);
    @(negedge clk); clear_inputs(); rst = 0;

    // CPU write alone.
    @(negedge clk);
    cpu_wr = 1; cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; cpu_rw_type = 3'b010; #1;
    check("wr_mem_en", mem_en, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("wr_rw_type", mem_rw_type, 3'b010);
    check("wr_stall", cpu_stall, 0);
    @(negedge clk); clear_inputs(); #1;
    check("idle_mem_en", mem_en, 0);
    check("idle_mem_addr", mem_addr, 0);
    check("idle_mem_wdata", mem_wdata, 0);

    // CPU read alone.
    @(negedge clk); cpu_rd = 1; cpu_addr = 32'h20; cpu_rw_type = 3'b010; #1;
    check("rd0_stall", cpu_stall, 1);
    check("rd0_mem_en", mem_en, 1);
    check("rd0_mem_we", mem_we, 0);
    check("rd0_mem_addr", mem_addr, 32'h20);
    @(negedge clk); #1;
    check("rd1_stall", cpu_stall, 0);
    check("rd1_rdata", cpu_rdata, 32'h1234_5678);
    check("rd1_mem_en", mem_en, 0);
    @(negedge clk); clear_inputs(); #1;
    check("rd2_rdata", cpu_rdata, 0);

    // CPU read and DMA read together right after reset.
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    cpu_rd = 1; cpu_addr = 32'h20;
    dma_req = 1; dma_we = 0; dma_addr = 32'h40; #1;
    check("tie0_stall", cpu_stall, 1);
    check("tie0_dma_gnt", dma_gnt, 0);
    check("tie0_mem_addr", mem_addr, 32'h20);
    @(negedge clk); #1;
    check("tie1_stall", cpu_stall, 0);
    check("tie1_rdata", cpu_rdata, 32'h1234_5678);
    check("tie1_dma_gnt", dma_gnt, 0);
    check("tie1_mem_en", mem_en, 0);
    @(negedge clk); cpu_rd = 0; #1;
    check("tie2_dma_gnt", dma_gnt, 1);
    check("tie2_mem_addr", mem_addr, 32'h40);
    check("tie2_mem_we", mem_we, 0);
    @(negedge clk); dma_req = 0; #1;
    check("tie3_rvalid", dma_rvalid, 0);
    check("tie3_mem_en", mem_en, 0);
    @(negedge clk); #1;
    check("tie4_rvalid", dma_rvalid, 1);
    check("tie4_rdata", dma_rdata, 32'hCAFE_F00D);
    @(negedge clk); #1;
    check("tie5_rvalid", dma_rvalid, 0);

    // Continuous writes from both sides alternate, CPU first (DMA won last).
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        cpu_wr = 1; cpu_addr = 32'h50; cpu_wdata = 32'h1111_1111;
        dma_req = 1; dma_we = 1; dma_addr = 32'h60; dma_wdata = 32'h2222_2222;
      end
      #1;
      check("alt_dma_gnt", dma_gnt, (k % 2));
      check("alt_stall", cpu_stall, (k % 2));
      check("alt_mem_addr", mem_addr, (k % 2) ? 32'h60 : 32'h50);
      check("alt_mem_en", mem_en, 1);
    end
    @(negedge clk); clear_inputs();

    // CPU read arriving while DMA read is outstanding.
    @(negedge clk); dma_req = 1; dma_we = 0; dma_addr = 32'h40; #1;
    check("dr0_dma_gnt", dma_gnt, 1);
    @(negedge clk); clear_inputs(); cpu_rd = 1; cpu_addr = 32'h20; #1;
    check("dr1_stall", cpu_stall, 1);
    check("dr1_mem_en", mem_en, 0);
    @(negedge clk); #1;
    check("dr2_stall", cpu_stall, 1);
    check("dr2_mem_en", mem_en, 1);
    check("dr2_mem_addr", mem_addr, 32'h20);
    check("dr2_rvalid", dma_rvalid, 1);
    check("dr2_dma_rdata", dma_rdata, 32'hCAFE_F00D);
    @(negedge clk); #1;
    check("dr3_stall", cpu_stall, 0);
    check("dr3_rdata", cpu_rdata, 32'h1234_5678);
    check("dr3_rvalid", dma_rvalid, 0);
    @(negedge clk); clear_inputs();

    // Reset during DMA_RD aborts the read.
    @(negedge clk); dma_req = 1; dma_we = 0; dma_addr = 32'h40; #1;
    check("ab0_dma_gnt", dma_gnt, 1);
    @(negedge clk); clear_inputs(); rst = 1; #1;
    check("ab1_mem_en", mem_en, 0);
    @(negedge clk); rst = 0; #1;
    check("ab2_rvalid", dma_rvalid, 0);
    check("ab2_mem_en", mem_en, 0);
    check("ab2_stall", cpu_stall, 0);
    @(negedge clk); cpu_wr = 1; cpu_addr = 32'h70; #1;
    check("ab3_rvalid", dma_rvalid, 0);
    check("ab3_mem_en", mem_en, 1);
    check("ab3_stall", cpu_stall, 0);
    @(negedge clk); clear_inputs();

    // Reset during CPU_RD aborts the read.
    @(negedge clk); cpu_rd = 1; cpu_addr = 32'h20; #1;
    check("cab0_stall", cpu_stall, 1);
    @(negedge clk); cpu_rd = 0; rst = 1; #1;
    check("cab1_mem_en", mem_en, 0);
    check("cab1_stall", cpu_stall, 0);
    @(negedge clk); rst = 0; #1;
    check("cab2_mem_en", mem_en, 0);
    check("cab2_rdata", cpu_rdata, 0);

    // rd and wr together behave as a write.
    @(negedge clk); cpu_rd = 1; cpu_wr = 1; cpu_addr = 32'h30; cpu_wdata = 32'h55; #1;
    check("rw_mem_we", mem_we, 1);
    check("rw_stall", cpu_stall, 0);
    check("rw_mem_wdata", mem_wdata, 32'h55);
    @(negedge clk); clear_inputs();

    // DMA write alone stays in IDLE.
    @(negedge clk);
    dma_req = 1; dma_we = 1; dma_addr = 32'h44; dma_wdata = 32'h77; dma_rw_type = 3'b001; #1;
    check("dw_dma_gnt", dma_gnt, 1);
    check("dw_mem_we", mem_we, 1);
    check("dw_rw_type", mem_rw_type, 3'b001);
    check("dw_mem_wdata", mem_wdata, 32'h77);
    @(negedge clk); clear_inputs(); cpu_wr = 1; cpu_addr = 32'h48; #1;
    check("dw_next_cpu_en", mem_en, 1);
    check("dw_next_stall", cpu_stall, 0);
    check("dw_next_rvalid", dma_rvalid, 0);
    @(negedge clk); clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
